// File: rtl/i2c_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_master_arbiter_if                                     |
// | Purpose  : Requester, response and i2c-master command bundle.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface i2c_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
) ();
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [7*NUM_REQ-1:0]      req_chip_addr;
    logic [8*NUM_REQ-1:0]      req_reg_addr;
    logic [DATA_W*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [3:0]                rsp_status;
    logic [6:0]                m_chip_addr;
    logic [7:0]                m_reg_addr;
    logic [DATA_W-1:0]         m_data_in;
    logic                      m_write_en;
    logic                      m_read_en;
    logic [DATA_W-1:0]         m_data_out;
    logic [3:0]                m_status;
    logic                      m_done;
    logic                      m_busy;
    logic                      busy;

    // Arbiter side
    modport master (
        input  req_valid, req_rw, req_chip_addr, req_reg_addr, req_wdata,
        input  m_data_out, m_status, m_done, m_busy,
        output req_grant, rsp_valid, rsp_rdata, rsp_status,
        output m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en, busy
    );

    // Requesters plus the i2c master
    modport slave (
        output req_valid, req_rw, req_chip_addr, req_reg_addr, req_wdata,
        output m_data_out, m_status, m_done, m_busy,
        input  req_grant, rsp_valid, rsp_rdata, rsp_status,
        input  m_chip_addr, m_reg_addr, m_data_in, m_write_en, m_read_en, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_master_arbiter                                        |
// | Purpose  : Round-robin share of one i2c master among NUM_REQ users.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module i2c_master_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset,
    i2c_master_arbiter_if.master bus
);
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST  = c_CNT_W'(BUSY_TIMEOUT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]         r_state;
    logic [c_IDX_W-1:0] r_last;
    logic [c_IDX_W-1:0] r_sel;
    logic               r_rw;
    logic [6:0]         r_chip;
    logic [7:0]         r_reg;
    logic [DATA_W-1:0]  r_wdata;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_rdata;
    logic [3:0]         r_status;

    logic               w_found;
    logic [c_IDX_W-1:0] w_win;
    logic [NUM_REQ-1:0] w_sel_oh;
    int                 w_k;

    // Scan starting one past the last winner so every requester gets a turn
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = (int'(r_last) + 1 + i) % NUM_REQ;
            if (!w_found && bus.req_valid[w_k]) begin
                w_found = 1'b1;
                w_win   = c_IDX_W'(w_k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last   <= c_LAST_INIT;
            r_sel    <= '0;
            r_rw     <= 1'b0;
            r_chip   <= '0;
            r_reg    <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_rw    <= bus.req_rw[w_win];
                        r_chip  <= bus.req_chip_addr[int'(w_win)*7 +: 7];
                        r_reg   <= bus.req_reg_addr[int'(w_win)*8 +: 8];
                        r_wdata <= bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.m_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_rdata  <= '0;
                        r_status <= 4'hF;
                        r_state  <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    // A done pulse coinciding with busy falling is one completion
                    if (bus.m_done || !bus.m_busy) begin
                        r_rdata  <= r_rw ? bus.m_data_out : '0;
                        r_status <= bus.m_status;
                        r_state  <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sel_oh = NUM_REQ'(1) << r_sel;

    assign bus.req_grant   = (r_state == ISSUE) ? w_sel_oh : '0;
    assign bus.rsp_valid   = (r_state == RESP)  ? w_sel_oh : '0;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_status  = r_status;
    assign bus.m_chip_addr = r_chip;
    assign bus.m_reg_addr  = r_reg;
    assign bus.m_data_in   = r_wdata;
    assign bus.m_write_en  = ((r_state == ISSUE) || (r_state == WAIT_BUSY)) && !r_rw;
    assign bus.m_read_en   = ((r_state == ISSUE) || (r_state == WAIT_BUSY)) && r_rw;
    assign bus.busy        = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_i2c_master_arbiter                                     |
// | Purpose  : Scoreboard bench with a behavioural i2c master model.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_i2c_master_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int DATA_W       = 16;
    localparam int BUSY_TIMEOUT = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    i2c_master_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rw, chip, reg, data} / {valid, rdata, status}
    logic [3:0]  exp_grant_q[$];
    logic [31:0] exp_cmd_q[$];
    logic [23:0] exp_rsp_q[$];

    logic [DATA_W-1:0] model_rdata;
    logic [3:0]        model_status;
    logic              model_nobusy;
    logic              model_use_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // i2c master model: busy two cycles after a strobe, completion three later
    initial begin : g_model
        int m_state;
        int cnt;
        logic [31:0] e;
        m_state = 0;
        cnt = 0;
        bus.m_busy = 1'b0;
        bus.m_done = 1'b0;
        bus.m_data_out = '0;
        bus.m_status = '0;
        forever begin
            @(negedge clk);
            bus.m_data_out = model_rdata;
            bus.m_status   = model_status;
            if (!reset) begin
                m_state = 0;
                bus.m_busy = 1'b0;
                bus.m_done = 1'b0;
            end else begin
                case (m_state)
                    0: if ((bus.m_write_en || bus.m_read_en) && !model_nobusy) begin
                        cnt = 0;
                        m_state = 1;
                    end
                    1: begin
                        cnt++;
                        if (cnt == 2) begin
                            chk("strobe_held", 64'(bus.m_write_en ^ bus.m_read_en), 64'd1);
                            if (exp_cmd_q.size() == 0) chk("unexpected_cmd", 64'd1, 64'd0);
                            else begin
                                e = exp_cmd_q.pop_front();
                                chk("cmd_fields", {32'd0, bus.m_read_en, bus.m_chip_addr,
                                                   bus.m_reg_addr, bus.m_data_in}, {32'd0, e});
                            end
                            bus.m_busy = 1'b1;
                            cnt = 0;
                            m_state = 2;
                        end
                    end
                    2: begin
                        if (cnt == 0)
                            chk("strobe_drop", 64'({bus.m_write_en, bus.m_read_en}), 64'd0);
                        cnt++;
                        if (cnt == 3) begin
                            bus.m_done = model_use_done;
                            bus.m_busy = 1'b0;
                            m_state = 3;
                        end
                    end
                    default: begin
                        bus.m_done = 1'b0;
                        m_state = 0;
                    end
                endcase
            end
        end
    end

    // Output monitor: scoreboard pops, one-hot and spacing checks
    initial begin : g_monitor
        int cyc;
        int last_g;
        bit have_g;
        logic [3:0]  eg;
        logic [23:0] er;
        cyc = 0;
        last_g = 0;
        have_g = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) have_g = 1'b0;
            if (bus.m_write_en || bus.m_read_en)
                chk("strobe_excl", 64'(bus.m_write_en & bus.m_read_en), 64'd0);
            if (bus.req_grant != '0) begin
                chk("grant_onehot", 64'($onehot(bus.req_grant)), 64'd1);
                if (have_g) chk("grant_spacing", 64'((cyc - last_g) >= 5), 64'd1);
                have_g = 1'b1;
                last_g = cyc;
                if (exp_grant_q.size() == 0) chk("unexpected_grant", 64'(bus.req_grant), 64'd0);
                else begin
                    eg = exp_grant_q.pop_front();
                    chk("grant", 64'(bus.req_grant), 64'(eg));
                end
            end
            if (bus.rsp_valid != '0) begin
                chk("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
                if (exp_rsp_q.size() == 0) chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                else begin
                    er = exp_rsp_q.pop_front();
                    chk("rsp", 64'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_status}), 64'(er));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [6:0] chip,
                           input logic [7:0] rg, input logic [15:0] wd);
        bus.req_rw[i]              = rw;
        bus.req_chip_addr[i*7 +: 7] = chip;
        bus.req_reg_addr[i*8 +: 8]  = rg;
        bus.req_wdata[i*16 +: 16]   = wd;
    endtask

    // Queue the expected command and response for one transaction
    task automatic expect_txn(input int i, input logic rw, input logic [6:0] chip,
                              input logic [7:0] rg, input logic [15:0] wd,
                              input logic [15:0] rd, input logic [3:0] st);
        logic [3:0] oh;
        oh = 4'd1 << i;
        exp_grant_q.push_back(oh);
        exp_cmd_q.push_back({rw, chip, rg, wd});
        exp_rsp_q.push_back({oh, rw ? rd : 16'h0000, st});
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_grant[i] && n < 200);
        chk("grant_wait", 64'(bus.req_grant[i]), 64'd1);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || exp_rsp_q.size() != 0) && n < 500);
        chk("quiet_wait", 64'(bus.busy || exp_rsp_q.size() != 0), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, 64'({bus.req_grant, bus.rsp_valid, bus.m_write_en, bus.m_read_en, bus.busy,
                      bus.rsp_status, bus.rsp_rdata, bus.m_chip_addr, bus.m_reg_addr,
                      bus.m_data_in}), 64'd0);
    endtask

    initial begin : g_main
        int n;
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_rw = '0;
        bus.req_chip_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_wdata = '0;
        model_rdata = 16'h0000;
        model_status = 4'h0;
        model_nobusy = 1'b0;
        model_use_done = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        reset = 1'b1;

        // single write from requester 0
        set_req(0, 1'b0, 7'h0F, 8'h0A, 16'hB2B2);
        expect_txn(0, 1'b0, 7'h0F, 8'h0A, 16'hB2B2, 16'h0, 4'h0);
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        wait_quiet();

        // read from requester 2
        model_rdata = 16'hC3C3;
        set_req(2, 1'b1, 7'h0F, 8'h10, 16'h0000);
        expect_txn(2, 1'b1, 7'h0F, 8'h10, 16'h0000, 16'hC3C3, 4'h0);
        bus.req_valid[2] = 1'b1;
        wait_grant(2);
        wait_quiet();
        model_rdata = 16'hEEEE;
        repeat (3) @(negedge clk);
        chk("rdata_hold", 64'(bus.rsp_rdata), 64'hC3C3);

        // write whose data changes after grant; completion by busy falling only
        model_status = 4'h5;
        model_use_done = 1'b0;
        set_req(1, 1'b0, 7'h22, 8'h33, 16'hD4D4);
        expect_txn(1, 1'b0, 7'h22, 8'h33, 16'hD4D4, 16'h0, 4'h5);
        bus.req_valid[1] = 1'b1;
        wait_grant(1);
        @(negedge clk);
        set_req(1, 1'b1, 7'h00, 8'h00, 16'h0000);
        wait_quiet();
        model_use_done = 1'b1;

        // requester 0 raises and withdraws while requester 3 is in flight
        model_status = 4'hA;
        set_req(3, 1'b0, 7'h55, 8'h66, 16'h7788);
        expect_txn(3, 1'b0, 7'h55, 8'h66, 16'h7788, 16'h0, 4'hA);
        bus.req_valid[3] = 1'b1;
        wait_grant(3);
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        wait_quiet();

        // busy timeout: master never answers
        model_nobusy = 1'b1;
        model_rdata = 16'hFFFF;
        set_req(3, 1'b1, 7'h11, 8'h12, 16'h0000);
        exp_grant_q.push_back(4'b1000);
        exp_rsp_q.push_back({4'b1000, 16'h0000, 4'hF});
        bus.req_valid[3] = 1'b1;
        wait_grant(3);
        n = bus.m_read_en ? 1 : 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus.m_read_en) break;
            n++;
        end
        chk("timeout_strobe_cycles", 64'(n), 64'(BUSY_TIMEOUT + 1));
        chk("timeout_in_resp", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("timeout_idle", 64'(bus.busy), 64'd0);
        model_nobusy = 1'b0;

        // reset while waiting for done
        model_status = 4'h0;
        set_req(2, 1'b0, 7'h44, 8'h45, 16'h4646);
        exp_grant_q.push_back(4'b0100);
        exp_cmd_q.push_back({1'b0, 7'h44, 8'h45, 16'h4646});
        bus.req_valid[2] = 1'b1;
        wait_grant(2);
        n = 0;
        while (!bus.m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("in_wait_done", 64'({bus.busy, bus.m_write_en}), 64'b10);
        reset = 1'b0;
        @(negedge clk);
        check_zero("mid_reset_outputs");
        @(negedge clk);
        reset = 1'b1;
        set_req(1, 1'b0, 7'h01, 8'h02, 16'h0101);
        set_req(3, 1'b0, 7'h03, 8'h04, 16'h0303);
        expect_txn(1, 1'b0, 7'h01, 8'h02, 16'h0101, 16'h0, 4'h0);
        expect_txn(3, 1'b0, 7'h03, 8'h04, 16'h0303, 16'h0, 4'h0);
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        wait_grant(1);
        wait_grant(3);
        wait_quiet();

        // all four held from reset: 0,1,2,3,0
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b0, 7'(8'h20 + i), 8'(8'h40 + i), 16'(16'h1000 * (i + 1)));
        for (int j = 0; j < 5; j++) begin
            int i;
            i = j % 4;
            expect_txn(i, 1'b0, 7'(8'h20 + i), 8'(8'h40 + i), 16'(16'h1000 * (i + 1)),
                       16'h0, 4'h0);
        end
        bus.req_valid = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 400 && n < 5; k++) begin
            @(negedge clk);
            if (bus.req_grant != '0) n++;
        end
        chk("rr_grant_count", 64'(n), 64'd5);
        bus.req_valid = '0;
        wait_quiet();

        repeat (4) @(negedge clk);
        chk("grant_q_empty", 64'(exp_grant_q.size()), 64'd0);
        chk("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
        chk("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one i2c master instance.
REQ-002 Parameter DATA_W, default 16: transaction data width (i2c master DATA_BYTES=2).
REQ-003 Parameter BUSY_TIMEOUT, default 32: clk cycles allowed between command issue and m_busy rising.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester transaction request, level; held until req_grant.
REQ-007 req_rw  in  NUM_REQ  per-requester direction; 1=read, 0=write.
REQ-008 req_chip_addr  in  7*NUM_REQ  per-requester 7-bit device address, flattened, requester 0 in LSBs.
REQ-009 req_reg_addr  in  8*NUM_REQ  per-requester register address, flattened.
REQ-010 req_wdata  in  DATA_W*NUM_REQ  per-requester write data, flattened.
REQ-011 req_grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted and fields captured.
REQ-012 rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished for that requester.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-014 rsp_status  out  4  master status at completion; 4'hF = arbiter busy-timeout; valid with rsp_valid.
REQ-015 m_chip_addr  out  7, m_reg_addr  out  8, m_data_in  out  DATA_W: command fields to i2c master.
REQ-016 m_write_en  out  1, m_read_en  out  1: command strobes to i2c master.
REQ-017 m_data_out  in  DATA_W, m_status  in  4, m_done  in  1, m_busy  in  1: from i2c master.
REQ-018 busy  out  1: high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-020 IDLE: if any req_valid bit set, select winner round-robin starting at (last_served+1) mod NUM_REQ, pulse req_grant for winner, latch its rw/chip/reg/wdata, go ISSUE.
REQ-021 last_served SHALL update to the winner index on grant; after reset it SHALL be NUM_REQ-1 so requester 0 wins first.
REQ-022 ISSUE: drive latched fields on m_* outputs; assert m_write_en (rw=0) or m_read_en (rw=1), never both; go WAIT_BUSY next cycle.
REQ-023 WAIT_BUSY: keep strobe and fields asserted; on m_busy=1 deassert strobe, go WAIT_DONE; timeout counter increments each cycle.
REQ-024 WAIT_BUSY: if counter reaches BUSY_TIMEOUT without m_busy, deassert strobe, set rsp_status=4'hF, rsp_rdata=0, go RESP.
REQ-025 WAIT_DONE: strobes low, m_* fields held; on m_done=1 or m_busy falling to 0, capture m_data_out (read only, else 0) and m_status, go RESP.
REQ-026 RESP: pulse rsp_valid for the granted index for exactly one cycle, go IDLE; rsp_rdata/rsp_status SHALL hold until the next RESP.
REQ-027 Grant latency: req_grant one cycle after req_valid seen in IDLE; minimum grant-to-next-grant spacing 5 cycles.
REQ-028 Changes to req_* inputs after grant SHALL NOT affect the in-flight transaction.
REQ-029 A requester deasserting req_valid before grant SHALL be skipped with no side effect.
REQ-030 A requester re-asserting req_valid during its own RESP cycle SHALL be arbitrated normally in the following IDLE cycle (no priority boost).
REQ-031 req_grant and rsp_valid SHALL never have more than one bit set.
REQ-032 m_done and m_busy fall in the same cycle SHALL be treated as a single completion.

Reset
REQ-033 reset=0 at posedge clk SHALL force IDLE, all outputs 0, last_served=NUM_REQ-1, timeout counter 0, from any state including mid-transaction.
REQ-034 Mid-transaction reset SHALL NOT generate rsp_valid for the aborted transaction; strobes drop the cycle after the reset edge.

Verification
REQ-035 Single write: req0 write chip 7'h0F reg 8'h0A data 16'hB2B2 -> one m_write_en sequence with those fields, rsp_valid=4'b0001, rsp_status=0.
REQ-036 Read: req2 read chip 7'h0F reg 8'h10, model returns 16'hC3C3 -> rsp_valid=4'b0100, rsp_rdata=16'hC3C3.
REQ-037 All four req_valid held high from reset -> grant order 0,1,2,3,0; no requester served twice before others.
REQ-038 Master model never raises m_busy -> after 32 cycles in WAIT_BUSY, rsp_status=4'hF, rsp_rdata=0, arbiter returns to IDLE.
REQ-039 reset=0 while in WAIT_DONE -> next cycle all outputs 0, no rsp_valid; after release req1 granted first if req0 idle.
REQ-040 Requester 1 changes req_wdata to 16'h0000 the cycle after grant of 16'hD4D4 -> master receives 16'hD4D4.
